// File: rtl/bitser_arb_ctrl.sv
// Bit-serial transmit controller: round-robin arbitration between two word
// requesters, then serialisation of the granted word through an 8:1 bit mux.

module bitser_mux8 (
  input  logic [7:0] data_i,
  input  logic [2:0] sel_i,
  output logic       bit_o
);
  assign bit_o = data_i[sel_i];
endmodule

module bitser_arb_ctrl #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_con_req0_valid,
  input  logic [7:0] i_data_req0_word,
  output logic       o_con_req0_ready,
  input  logic       i_con_req1_valid,
  input  logic [7:0] i_data_req1_word,
  output logic       o_con_req1_ready,
  input  logic       i_con_out_ready,
  output logic       o_con_bit_valid,
  output logic       o_data_bit,
  output logic       o_con_last,
  output logic       o_con_owner,
  output logic [2:0] o_con_choice
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [7:0] word_q, word_d;
  logic [2:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;

  logic       shifting, cnt_last, accept_win;
  logic       gnt_any, gnt_sel, accept;
  logic [7:0] gnt_word;
  logic [2:0] choice;

  assign shifting   = (state_q == S_SHIFT);
  assign cnt_last   = (cnt_q == 3'd7);
  // A new word may also be taken on the cycle the final bit leaves, so
  // consecutive words stream without a bubble.
  assign accept_win = !shifting || (cnt_last && i_con_out_ready);

  assign gnt_any  = i_con_req0_valid || i_con_req1_valid;
  assign gnt_sel  = (i_con_req0_valid && i_con_req1_valid) ? ~last_owner_q : i_con_req1_valid;
  assign gnt_word = gnt_sel ? i_data_req1_word : i_data_req0_word;

  assign o_con_req0_ready = accept_win && gnt_any && !gnt_sel;
  assign o_con_req1_ready = accept_win && gnt_any && gnt_sel;
  assign accept           = o_con_req0_ready || o_con_req1_ready;

  assign choice = MSB_FIRST ? (3'd7 - cnt_q) : cnt_q;

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    if (accept) begin
      word_d       = gnt_word;
      owner_d      = gnt_sel;
      last_owner_d = gnt_sel;
      cnt_d        = 3'd0;
      state_d      = S_SHIFT;
    end else if (shifting && i_con_out_ready) begin
      if (cnt_last) begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      word_q       <= 8'd0;
      cnt_q        <= 3'd0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  bitser_mux8 u_mux (
    .data_i (word_q),
    .sel_i  (choice),
    .bit_o  (o_data_bit)
  );

  assign o_con_bit_valid = shifting;
  assign o_con_last      = shifting && cnt_last;
  assign o_con_owner     = owner_q;
  assign o_con_choice    = choice;
endmodule

// File: tb/tb_bitser_arb_ctrl.sv
// Scoreboard bench: two instances (LSB-first and MSB-first) share stimulus;
// each has its own expected-bit queue drained by a monitor on accepted bits.

module tb_bitser_arb_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0, ordy = 1'b0;
  logic [7:0] w0 = 8'd0, w1 = 8'd0;

  logic r0_a, r1_a, bv_a, bit_a, last_a, own_a;
  logic r0_b, r1_b, bv_b, bit_b, last_b, own_b;
  logic [2:0] ch_a, ch_b;

  typedef struct packed {
    logic       b;
    logic       last;
    logic       own;
    logic [2:0] ch;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bitser_arb_ctrl #(.MSB_FIRST(1'b0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_con_req0_valid(v0), .i_data_req0_word(w0), .o_con_req0_ready(r0_a),
    .i_con_req1_valid(v1), .i_data_req1_word(w1), .o_con_req1_ready(r1_a),
    .i_con_out_ready(ordy), .o_con_bit_valid(bv_a), .o_data_bit(bit_a),
    .o_con_last(last_a), .o_con_owner(own_a), .o_con_choice(ch_a)
  );

  bitser_arb_ctrl #(.MSB_FIRST(1'b1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_con_req0_valid(v0), .i_data_req0_word(w0), .o_con_req0_ready(r0_b),
    .i_con_req1_valid(v1), .i_data_req1_word(w1), .o_con_req1_ready(r1_b),
    .i_con_out_ready(ordy), .o_con_bit_valid(bv_b), .o_data_bit(bit_b),
    .o_con_last(last_b), .o_con_owner(own_b), .o_con_choice(ch_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [7:0] w, input logic own);
    for (int i = 0; i < 8; i++) begin
      q_a.push_back({w[i], (i == 7), own, 3'(i)});
      q_b.push_back({w[7-i], (i == 7), own, 3'(7 - i)});
    end
  endtask

  // Outputs are compared to the queue head on every valid cycle (so stalled
  // bits must hold steady) and the head retires only on an accepted transfer.
  always @(negedge clk) begin
    if (rst_n && bv_a) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_bit: got bit_valid=1 expected 0 at %0t", $time);
      end else begin
        chk("a_bit", int'(bit_a), int'(q_a[0].b));
        chk("a_last", int'(last_a), int'(q_a[0].last));
        chk("a_owner", int'(own_a), int'(q_a[0].own));
        chk("a_choice", int'(ch_a), int'(q_a[0].ch));
        if (ordy) void'(q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bv_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_bit: got bit_valid=1 expected 0 at %0t", $time);
      end else begin
        chk("b_bit", int'(bit_b), int'(q_b[0].b));
        chk("b_last", int'(last_b), int'(q_b[0].last));
        chk("b_owner", int'(own_b), int'(q_b[0].own));
        chk("b_choice", int'(ch_b), int'(q_b[0].ch));
        if (ordy) void'(q_b.pop_front());
      end
    end
  end

  task automatic chk_drained(input string name);
    chk({name, "_valid_a"}, int'(bv_a), 0);
    chk({name, "_valid_b"}, int'(bv_b), 0);
    chk({name, "_q_a"}, q_a.size(), 0);
    chk({name, "_q_b"}, q_b.size(), 0);
    $display("%s: done", name);
  endtask

  initial begin
    // reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(bv_a), 0);
    chk("rst_last", int'(last_a), 0);
    chk("rst_bit", int'(bit_a), 0);
    chk("rst_owner", int'(own_a), 0);
    chk("rst_choice_a", int'(ch_a), 0);
    chk("rst_choice_b", int'(ch_b), 7);
    chk("rst_ready0", int'(r0_a), 0);
    chk("rst_ready1", int'(r1_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // single word A5, out_ready high
    v0 = 1'b1; w0 = 8'hA5; ordy = 1'b1;
    #1;
    chk("a5_ready0", int'(r0_a), 1);
    chk("a5_ready1", int'(r1_a), 0);
    push_word(8'hA5, 1'b0);
    tick(1);
    v0 = 1'b0;
    tick(8);
    chk_drained("word_a5");

    // 81 with out_ready toggling 1,0
    v0 = 1'b1; w0 = 8'h81; ordy = 1'b1;
    push_word(8'h81, 1'b0);
    tick(1);
    v0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ordy = (i % 2 == 0);
      tick(1);
    end
    ordy = 1'b1;
    tick(1);
    chk_drained("word_81_stall");

    // back-to-back: req1 arrives during req0's 5th bit
    v0 = 1'b1; w0 = 8'h3C; ordy = 1'b1;
    push_word(8'h3C, 1'b0);
    push_word(8'hC3, 1'b1);
    tick(1);
    v0 = 1'b0;
    tick(4);
    v1 = 1'b1; w1 = 8'hC3;
    for (int c = 5; c <= 8; c++) begin
      #1;
      chk("b2b_ready1", int'(r1_a), (c == 8) ? 1 : 0);
      chk("b2b_ready0", int'(r0_a), 0);
      tick(1);
    end
    v1 = 1'b0;
    tick(8);
    chk_drained("back_to_back");

    // downstream held off on the last bit
    v0 = 1'b1; w0 = 8'h5A; ordy = 1'b1;
    push_word(8'h5A, 1'b0);
    tick(1);
    v0 = 1'b0;
    tick(7);
    ordy = 1'b0; v0 = 1'b1; v1 = 1'b1; w0 = 8'h11; w1 = 8'h22;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_ready0", int'(r0_a), 0);
      chk("hold_ready1", int'(r1_a), 0);
      chk("hold_last", int'(last_a), 1);
      chk("hold_valid", int'(bv_a), 1);
      tick(1);
    end
    v0 = 1'b0; v1 = 1'b0; ordy = 1'b1;
    tick(1);
    chk_drained("held_off_last");

    // reset asserted at cnt==3 of a req1 word
    v1 = 1'b1; w1 = 8'h77; ordy = 1'b1;
    push_word(8'h77, 1'b1);
    tick(1);
    v1 = 1'b0;
    tick(3);
    chk("mid_choice_pre", int'(ch_a), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bv_a), 0);
    chk("mid_rst_last", int'(last_a), 0);
    chk("mid_rst_bit", int'(bit_a), 0);
    chk("mid_rst_owner", int'(own_a), 0);
    chk("mid_rst_choice_a", int'(ch_a), 0);
    chk("mid_rst_choice_b", int'(ch_b), 7);
    q_a.delete();
    q_b.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("mid_no_resume", int'(bv_a), 0);
    $display("reset_mid_word: done");

    // both valid continuously: alternate 0,1,0,1 starting with req0
    v0 = 1'b1; w0 = 8'h0F; v1 = 1'b1; w1 = 8'hF0; ordy = 1'b1;
    push_word(8'h0F, 1'b0);
    push_word(8'hF0, 1'b1);
    push_word(8'h0F, 1'b0);
    push_word(8'hF0, 1'b1);
    for (int c = 0; c <= 24; c++) begin
      #1;
      chk("rr_ready0", int'(r0_a), (c == 0 || c == 16) ? 1 : 0);
      chk("rr_ready1", int'(r1_a), (c == 8 || c == 24) ? 1 : 0);
      tick(1);
    end
    v0 = 1'b0; v1 = 1'b0;
    tick(8);
    chk_drained("round_robin");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bitser_arb_ctrl.md
# bitser_arb_ctrl

Bit-serial transmit controller that shares the 8:1 bit-select mux between two parallel-word requesters. It accepts an 8-bit word from one requester at a time over a valid/ready handshake and holds it on the mux data input. It then steps the mux select through all 8 positions, presenting one bit per accepted downstream transfer. It sits between the parallel word sources and the serial datapath, and instantiates the existing 8:1 mux internally.

## Interface
Parameters:
- MSB_FIRST, 0, bit order: 0 = bit 0 first (select 0→7), 1 = bit 7 first (select 7→0)

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_con_req0_valid  in  1  requester 0 has a word
- i_data_req0_word  in  8  requester 0 word
- o_con_req0_ready  out  1  requester 0 word accepted this cycle when valid&ready
- i_con_req1_valid  in  1  requester 1 has a word
- i_data_req1_word  in  8  requester 1 word
- o_con_req1_ready  out  1  requester 1 accept strobe
- i_con_out_ready  in  1  downstream accepts current bit
- o_con_bit_valid  out  1  o_data_bit is valid
- o_data_bit  out  1  current serial bit (mux output)
- o_con_last  out  1  current bit is the 8th bit of the word
- o_con_owner  out  1  requester whose word is being serialised
- o_con_choice  out  3  current mux select (debug/observe)

## Operation
- States: IDLE, SHIFT. Registers: word[7:0], cnt[2:0], owner, last_owner.
- Grant (combinational): only one valid → that requester; both valid → requester != last_owner (round robin); none → no grant.
- Accept window: state==IDLE, or state==SHIFT && cnt==7 && i_con_out_ready (zero-bubble back-to-back). Only the granted requester sees ready=1, and only inside the accept window; the other ready is 0.
- On accept of requester k: word←data_k, owner←k, last_owner←k, cnt←0, state←SHIFT.
- Last bit accepted with no new accept: state←IDLE, cnt←0.
- SHIFT: o_con_bit_valid=1; choice = MSB_FIRST ? 7−cnt : cnt; o_data_bit = word[choice] via mux; o_con_last = (cnt==7). When i_con_out_ready=1: cnt←cnt+1 (wraps 7→0 only alongside a state change or re-accept).
- Stall (bit_valid && !out_ready): word, cnt, owner, and all outputs held stable.
- IDLE: o_con_bit_valid=0, o_con_last=0; o_data_bit/o_con_choice reflect held word and cnt=0 and are don't-care to downstream.
- A valid dropped before acceptance is simply not granted; no request is latched.

## Timing
- Reset values: state IDLE, word 0, cnt 0, owner 0, last_owner 1 (req0 wins first tie). Outputs: o_con_bit_valid 0, o_con_last 0, o_data_bit 0, o_con_owner 0, o_con_choice 0 (7 if MSB_FIRST). Readies are 0 unless a valid is present, since readies follow the grant.
- Latency: accepted in cycle T → first bit valid in T+1.
- With out_ready held high: bits in T+1..T+8, last in T+8. A waiting word is accepted in T+8, and its first bit appears in T+9. Throughput 1 bit/cycle, no gap.
- Readies depend combinationally on valids, state, cnt, and i_con_out_ready. No combinational path exists from any input to o_con_bit_valid/o_data_bit/o_con_last.
- Reset asserted mid-word: word abandoned immediately, outputs return to reset values asynchronously, and no further bits are emitted.

## Test plan
- Single word, MSB_FIRST=0: req0 sends 8'hA5, out_ready=1 → bits 1,0,1,0,0,1,0,1 on cycles T+1..T+8, last only at T+8, owner=0, then bit_valid=0.
- MSB_FIRST=1, 8'h81 with out_ready toggling 1,0 each cycle → bits 1,0,0,0,0,0,0,1, each held stable through stall cycles, choice 7→0.
- Both requesters valid continuously (req0=8'h0F, req1=8'hF0) → accepts alternate 0,1,0,1 starting with req0; 8 bits per word with no idle cycle between words.
- Back-to-back: req1 valid arrives during req0's 5th bit → req1 ready only in cycle with cnt==7 && out_ready; req1's first bit follows immediately.
- Downstream held off (out_ready=0) at cnt==7 → both readies 0 and last stays asserted until out_ready rises.
- Reset pulse at cnt==3 → outputs at reset values same cycle. After release, req0 wins the first tie, and the previous word is never resumed.
